// File: rtl/btb_update_queue_pkg.sv
// Shared types for the BTB update queue: update packet layout, resolved-branch
// record and a helper that builds a valid packet from a branch.
package btb_update_queue_pkg;

  localparam int SRC_W       = 31;
  localparam int UPD_W       = 67;
  localparam int UPD_SRC_LSB = 36;
  localparam int UPD_DST_LSB = 4;
  localparam int UPD_JMP_BIT = 2;
  localparam int UPD_CMP_BIT = 1;
  localparam int UPD_VLD_BIT = 0;

  typedef struct packed {
    logic [SRC_W-1:0] src;
    logic             pad0;
    logic [SRC_W-1:0] dst;
    logic             pad1;
    logic             isJump;
    logic             compr;
    logic             valid;
  } bt_update_t;

  typedef struct packed {
    logic             valid;
    logic [SRC_W-1:0] src;
    logic [SRC_W-1:0] dst;
    logic             isJump;
    logic             compr;
    logic             taken;
    logic             btbHit;
  } br_res_t;

  function automatic bt_update_t mk_update(br_res_t b);
    bt_update_t u;
    u        = '0;
    u.src    = b.src;
    u.dst    = b.dst;
    u.isJump = b.isJump;
    u.compr  = b.compr;
    u.valid  = 1'b1;
    return u;
  endfunction

endpackage

// File: rtl/btb_upd_fifo.sv
// Generic DEPTH x W synchronous FIFO; exposes occupancy, a per-entry live mask
// and a key slice of every entry so the owner can do associative lookups.
module btb_upd_fifo #(
  parameter int DEPTH   = 4,
  parameter int W       = 67,
  parameter int KEY_LSB = 36,
  parameter int KEY_W   = 31,
  localparam int AW     = $clog2(DEPTH)
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            push_i,
  input  logic                            pop_i,
  input  logic [W-1:0]                    wdata_i,
  output logic [W-1:0]                    rdata_o,
  output logic [AW:0]                     count_o,
  output logic [DEPTH-1:0]                live_o,
  output logic [DEPTH-1:0][KEY_W-1:0]     keys_o
);

  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  logic [DEPTH-1:0][W-1:0] mem_q;
  logic [AW-1:0]           wptr_q, rptr_q;
  logic [AW:0]             count_q, count_d;
  logic                    do_push, do_pop;

  // A push into a full FIFO is only legal when a pop frees the slot this cycle.
  assign do_pop  = pop_i && (count_q != '0);
  assign do_push = push_i && ((count_q != FULL_CNT) || do_pop);

  always_comb begin
    count_d = count_q;
    if (do_push && !do_pop)      count_d = count_q + 1'b1;
    else if (do_pop && !do_push) count_d = count_q - 1'b1;
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
    end else begin
      if (do_push) begin
        mem_q[wptr_q] <= wdata_i;
        wptr_q        <= wptr_q + 1'b1;
      end
      if (do_pop) rptr_q <= rptr_q + 1'b1;
      count_q <= count_d;
    end
  end

  assign rdata_o = mem_q[rptr_q];
  assign count_o = count_q;

  for (genvar i = 0; i < DEPTH; i++) begin : g_ent
    logic [AW-1:0] off;
    assign off       = AW'(i) - rptr_q;
    assign live_o[i] = {1'b0, off} < count_q;
    assign keys_o[i] = mem_q[i][KEY_LSB +: KEY_W];
  end

endmodule

// File: rtl/btb_update_queue.sv
// BTB write-side producer: filters/dedups missed taken branches, queues them
// and emits one update packet per cycle. BTB_UPD_STATS_EN enables the drop counter.
module btb_update_queue
  import btb_update_queue_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              IN_brValid,
  input  logic [30:0]       IN_brSrc,
  input  logic [30:0]       IN_brDst,
  input  logic              IN_brIsJump,
  input  logic              IN_brCompr,
  input  logic              IN_brTaken,
  input  logic              IN_brBtbHit,
  input  logic              IN_btReady,
  output logic [66:0]       OUT_btUpdate,
  output logic              OUT_full,
  output logic [15:0]       OUT_dropCnt
);

  localparam int          AW       = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  br_res_t                      br;
  bt_update_t                   out_q, head;
  logic [AW:0]                  count;
  logic [DEPTH-1:0]             live, ent_hit;
  logic [DEPTH-1:0][SRC_W-1:0]  keys;
  logic                         cand, dup, pop, push;

  always_comb begin
    br        = '0;
    br.valid  = IN_brValid;
    br.src    = IN_brSrc;
    br.dst    = IN_brDst;
    br.isJump = IN_brIsJump;
    br.compr  = IN_brCompr;
    br.taken  = IN_brTaken;
    br.btbHit = IN_brBtbHit;
  end

  assign cand = br.valid && (br.taken || br.isJump) && !br.btbHit;

  for (genvar i = 0; i < DEPTH; i++) begin : g_dup
    assign ent_hit[i] = live[i] && (keys[i] == br.src);
  end

  // The in-flight output packet counts as queued for dedup purposes.
  assign dup  = (|ent_hit) || (out_q.valid && (out_q.src == br.src));
  assign pop  = (count != '0) && (!out_q.valid || IN_btReady);
  assign push = cand && !dup && ((count != FULL_CNT) || pop);

  btb_upd_fifo #(
    .DEPTH   (DEPTH),
    .W       (UPD_W),
    .KEY_LSB (UPD_SRC_LSB),
    .KEY_W   (SRC_W)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .push_i  (push),
    .pop_i   (pop),
    .wdata_i (mk_update(br)),
    .rdata_o (head),
    .count_o (count),
    .live_o  (live),
    .keys_o  (keys)
  );

  always_ff @(posedge clk) begin
    if (!rst)            out_q       <= '0;
    else if (pop)        out_q       <= head;
    else if (IN_btReady) out_q.valid <= 1'b0;
  end

  assign OUT_btUpdate = out_q;
  assign OUT_full     = (count == FULL_CNT);

`ifdef BTB_UPD_STATS_EN
  logic [15:0] drop_cnt_q;
  logic        drop;
  assign drop = cand && !push;

  always_ff @(posedge clk) begin
    if (!rst)                               drop_cnt_q <= '0;
    else if (drop && drop_cnt_q != 16'hFFFF) drop_cnt_q <= drop_cnt_q + 16'd1;
  end

  assign OUT_dropCnt = drop_cnt_q;
`else
  assign OUT_dropCnt = '0;
`endif

endmodule

// File: tb/tb_btb_update_queue.sv
// Directed self-checking bench for btb_update_queue (DEPTH=4).
module tb_btb_update_queue;

  logic        clk = 1'b0;
  logic        rst;
  logic        IN_brValid, IN_brIsJump, IN_brCompr, IN_brTaken, IN_brBtbHit, IN_btReady;
  logic [30:0] IN_brSrc, IN_brDst;
  logic [66:0] OUT_btUpdate;
  logic        OUT_full;
  logic [15:0] OUT_dropCnt;

  int checks = 0;
  int errors = 0;
  int exp_drop = 0;

  btb_update_queue #(.DEPTH(4)) dut (
    .clk          (clk),
    .rst          (rst),
    .IN_brValid   (IN_brValid),
    .IN_brSrc     (IN_brSrc),
    .IN_brDst     (IN_brDst),
    .IN_brIsJump  (IN_brIsJump),
    .IN_brCompr   (IN_brCompr),
    .IN_brTaken   (IN_brTaken),
    .IN_brBtbHit  (IN_brBtbHit),
    .IN_btReady   (IN_btReady),
    .OUT_btUpdate (OUT_btUpdate),
    .OUT_full     (OUT_full),
    .OUT_dropCnt  (OUT_dropCnt)
  );

  always #5 clk = ~clk;

  function automatic logic [66:0] pkt(input logic [30:0] s, input logic [30:0] d,
                                      input logic j, input logic c);
    return {s, 1'b0, d, 1'b0, j, c, 1'b1};
  endfunction

  function automatic logic [15:0] exp_dc();
`ifdef BTB_UPD_STATS_EN
    return 16'(exp_drop);
`else
    return 16'd0;
`endif
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_br(input logic [30:0] s, input logic [30:0] d,
                        input logic j, input logic c);
    IN_brValid = 1'b1; IN_brSrc = s; IN_brDst = d;
    IN_brIsJump = j; IN_brCompr = c; IN_brTaken = 1'b1; IN_brBtbHit = 1'b0;
  endtask

  task automatic idle();
    IN_brValid = 1'b0; IN_brTaken = 1'b0; IN_brIsJump = 1'b0; IN_brBtbHit = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b0; idle(); IN_brSrc = '0; IN_brDst = '0; IN_brCompr = 1'b0; IN_btReady = 1'b0;
    tick(); tick();
    checks++; if (OUT_btUpdate !== 67'd0) begin errors++; $display("FAIL reset_pkt got %h want 0", OUT_btUpdate); end
    checks++; if (OUT_full !== 1'b0) begin errors++; $display("FAIL reset_full got %b want 0", OUT_full); end
    checks++; if (OUT_dropCnt !== 16'd0) begin errors++; $display("FAIL reset_drop got %0d want 0", OUT_dropCnt); end
    rst = 1'b1;
    tick();
  endtask

  task automatic test_basic();
    IN_btReady = 1'b1;
    set_br(31'h100, 31'h2000, 1'b0, 1'b1);
    tick(); idle();
    checks++; if (OUT_btUpdate[0] !== 1'b0) begin errors++; $display("FAIL basic_nobypass got %b want 0", OUT_btUpdate[0]); end
    tick();
    checks++; if (OUT_btUpdate !== pkt(31'h100, 31'h2000, 1'b0, 1'b1)) begin errors++; $display("FAIL basic_pkt got %h want %h", OUT_btUpdate, pkt(31'h100, 31'h2000, 1'b0, 1'b1)); end
    tick();
    checks++; if (OUT_btUpdate[0] !== 1'b0) begin errors++; $display("FAIL basic_drop_valid got %b want 0", OUT_btUpdate[0]); end
  endtask

  task automatic test_filter();
    IN_btReady = 1'b1;
    set_br(31'h150, 31'h250, 1'b0, 1'b0); IN_brBtbHit = 1'b1;
    tick();
    set_br(31'h160, 31'h260, 1'b0, 1'b0); IN_brTaken = 1'b0;
    tick(); idle(); tick(); tick();
    checks++; if (OUT_btUpdate[0] !== 1'b0) begin errors++; $display("FAIL filter_valid got %b want 0", OUT_btUpdate[0]); end
    checks++; if (OUT_dropCnt !== exp_dc()) begin errors++; $display("FAIL filter_drop got %0d want %0d", OUT_dropCnt, exp_dc()); end
    // Not-taken unconditional jump is still a candidate.
    set_br(31'h500, 31'h600, 1'b1, 1'b0); IN_brTaken = 1'b0;
    tick(); idle(); tick();
    checks++; if (OUT_btUpdate !== pkt(31'h500, 31'h600, 1'b1, 1'b0)) begin errors++; $display("FAIL filter_jump got %h want %h", OUT_btUpdate, pkt(31'h500, 31'h600, 1'b1, 1'b0)); end
    tick();
  endtask

  task automatic test_dedup();
    IN_btReady = 1'b0;
    set_br(31'h40, 31'h80, 1'b1, 1'b0);
    tick(); tick(); idle(); exp_drop++;
    tick();
    checks++; if (OUT_btUpdate !== pkt(31'h40, 31'h80, 1'b1, 1'b0)) begin errors++; $display("FAIL dedup_pkt got %h want %h", OUT_btUpdate, pkt(31'h40, 31'h80, 1'b1, 1'b0)); end
    checks++; if (OUT_dropCnt !== exp_dc()) begin errors++; $display("FAIL dedup_drop got %0d want %0d", OUT_dropCnt, exp_dc()); end
    IN_btReady = 1'b1;
    tick();
    checks++; if (OUT_btUpdate[0] !== 1'b0) begin errors++; $display("FAIL dedup_single got %b want 0", OUT_btUpdate[0]); end
    tick();
    checks++; if (OUT_btUpdate[0] !== 1'b0) begin errors++; $display("FAIL dedup_empty got %b want 0", OUT_btUpdate[0]); end
  endtask

  task automatic test_overflow();
    IN_btReady = 1'b0;
    for (int i = 0; i < 6; i++) begin
      set_br(31'h200 + 31'(i), 31'h3000 + 31'(i), 1'b0, 1'b0);
      tick();
    end
    idle(); exp_drop++;
    checks++; if (OUT_full !== 1'b1) begin errors++; $display("FAIL ovf_full got %b want 1", OUT_full); end
    checks++; if (OUT_btUpdate !== pkt(31'h200, 31'h3000, 1'b0, 1'b0)) begin errors++; $display("FAIL ovf_head got %h want %h", OUT_btUpdate, pkt(31'h200, 31'h3000, 1'b0, 1'b0)); end
    checks++; if (OUT_dropCnt !== exp_dc()) begin errors++; $display("FAIL ovf_drop got %0d want %0d", OUT_dropCnt, exp_dc()); end
    IN_btReady = 1'b1;
    for (int i = 1; i < 5; i++) begin
      tick();
      checks++; if (OUT_btUpdate !== pkt(31'h200 + 31'(i), 31'h3000 + 31'(i), 1'b0, 1'b0)) begin errors++; $display("FAIL ovf_drain%0d got %h want %h", i, OUT_btUpdate, pkt(31'h200 + 31'(i), 31'h3000 + 31'(i), 1'b0, 1'b0)); end
      if (i == 1) begin
        checks++; if (OUT_full !== 1'b0) begin errors++; $display("FAIL ovf_unfull got %b want 0", OUT_full); end
      end
    end
    tick();
    checks++; if (OUT_btUpdate[0] !== 1'b0) begin errors++; $display("FAIL ovf_end got %b want 0", OUT_btUpdate[0]); end
  endtask

  task automatic test_simultaneous();
    IN_btReady = 1'b0;
    for (int i = 0; i < 5; i++) begin
      set_br(31'h300 + 31'(i), 31'h700 + 31'(i), 1'b0, 1'b1);
      tick();
    end
    checks++; if (OUT_full !== 1'b1) begin errors++; $display("FAIL sim_full got %b want 1", OUT_full); end
    set_br(31'h305, 31'h705, 1'b0, 1'b1); IN_btReady = 1'b1;
    tick(); idle();
    checks++; if (OUT_full !== 1'b1) begin errors++; $display("FAIL sim_stillfull got %b want 1", OUT_full); end
    checks++; if (OUT_btUpdate !== pkt(31'h301, 31'h701, 1'b0, 1'b1)) begin errors++; $display("FAIL sim_first got %h want %h", OUT_btUpdate, pkt(31'h301, 31'h701, 1'b0, 1'b1)); end
    for (int i = 2; i < 6; i++) begin
      tick();
      checks++; if (OUT_btUpdate !== pkt(31'h300 + 31'(i), 31'h700 + 31'(i), 1'b0, 1'b1)) begin errors++; $display("FAIL sim_drain%0d got %h want %h", i, OUT_btUpdate, pkt(31'h300 + 31'(i), 31'h700 + 31'(i), 1'b0, 1'b1)); end
    end
    tick();
    checks++; if (OUT_btUpdate[0] !== 1'b0) begin errors++; $display("FAIL sim_end got %b want 0", OUT_btUpdate[0]); end
    checks++; if (OUT_dropCnt !== exp_dc()) begin errors++; $display("FAIL sim_drop got %0d want %0d", OUT_dropCnt, exp_dc()); end
  endtask

  task automatic test_reset_mid();
    IN_btReady = 1'b0;
    for (int i = 0; i < 4; i++) begin
      set_br(31'h400 + 31'(i), 31'h900 + 31'(i), 1'b1, 1'b1);
      tick();
    end
    idle();
    checks++; if (OUT_btUpdate[0] !== 1'b1) begin errors++; $display("FAIL rmid_pre got %b want 1", OUT_btUpdate[0]); end
    rst = 1'b0;
    tick();
    exp_drop = 0;
    checks++; if (OUT_btUpdate !== 67'd0) begin errors++; $display("FAIL rmid_pkt got %h want 0", OUT_btUpdate); end
    checks++; if (OUT_full !== 1'b0) begin errors++; $display("FAIL rmid_full got %b want 0", OUT_full); end
    checks++; if (OUT_dropCnt !== 16'd0) begin errors++; $display("FAIL rmid_drop got %0d want 0", OUT_dropCnt); end
    rst = 1'b1; IN_btReady = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++; if (OUT_btUpdate[0] !== 1'b0) begin errors++; $display("FAIL rmid_stale%0d got %b want 0", i, OUT_btUpdate[0]); end
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_filter();
    test_dedup();
    test_overflow();
    test_simultaneous();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
